// File: rtl/mem_access_ctrl.sv
// Load/store access controller between the MEM stage and a byte-banked, big-endian data RAM.
// Handles lane selection, store-data placement, load extension/merge, and a ce/ack handshake with timeout.
module mem_access_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] rdata_out,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    // state  | meaning
    // IDLE   | waiting for a valid, aligned request
    // ACCESS | ce asserted, waiting for ack or timeout
    // RESP   | one-cycle done pulse with result / bus_err
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [3:0] OP_LB  = 4'd0,  OP_LBU = 4'd1,  OP_LH  = 4'd2,  OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4,  OP_LWL = 4'd5,  OP_LWR = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd8,  OP_SH  = 4'd9,  OP_SW  = 4'd10;
    localparam logic [3:0] OP_SWL = 4'd11, OP_SWR = 4'd12;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    function automatic logic op_is_valid(input logic [3:0] o);
        case (o)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
            OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_misaligned(input logic [3:0] o, input logic [1:0] a);
        case (o)
            OP_LH, OP_LHU, OP_SH: return a[0];
            OP_LW, OP_SW:         return |a;
            default:              return 1'b0;
        endcase
    endfunction

    logic req_bad_align;
    logic accept;

    assign req_bad_align = op_is_misaligned(op, addr[1:0]);
    // Gated by rst so nothing combinational leaks out while reset is held.
    assign misalign      = rst & req_valid & req_bad_align;
    assign accept        = rst & req_valid & op_is_valid(op) & ~req_bad_align;

    logic [1:0]  off;
    logic [31:0] ld_shift;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [3:0]  store_sel;
    logic [31:0] store_data;

    assign off      = addr_q[1:0];
    assign ld_shift = mem_rdata >> {~off, 3'b000};
    assign ld_half  = off[1] ? mem_rdata[15:0] : mem_rdata[31:16];

    always_comb begin
        load_data = mem_rdata;
        case (op_q)
            OP_LB:  load_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            OP_LBU: load_data = {24'b0, ld_shift[7:0]};
            OP_LH:  load_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU: load_data = {16'b0, ld_half};
            OP_LWL: begin
                case (off)
                    2'd0:    load_data = mem_rdata;
                    2'd1:    load_data = {mem_rdata[23:0], wdata_q[7:0]};
                    2'd2:    load_data = {mem_rdata[15:0], wdata_q[15:0]};
                    default: load_data = {mem_rdata[7:0], wdata_q[23:0]};
                endcase
            end
            OP_LWR: begin
                case (off)
                    2'd0:    load_data = {wdata_q[31:8], mem_rdata[31:24]};
                    2'd1:    load_data = {wdata_q[31:16], mem_rdata[31:16]};
                    2'd2:    load_data = {wdata_q[31:24], mem_rdata[31:8]};
                    default: load_data = mem_rdata;
                endcase
            end
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        store_sel  = 4'b1111;
        store_data = wdata_q;
        case (op_q)
            OP_SB: begin
                store_sel  = 4'b1000 >> off;
                store_data = {4{wdata_q[7:0]}};
            end
            OP_SH: begin
                store_sel  = off[1] ? 4'b0011 : 4'b1100;
                store_data = {2{wdata_q[15:0]}};
            end
            OP_SWL: begin
                store_sel  = 4'b1111 >> off;
                store_data = wdata_q >> {off, 3'b000};
            end
            OP_SWR: begin
                store_sel  = 4'b1111 << ~off;
                store_data = wdata_q << {~off, 3'b000};
            end
            default: begin
                store_sel  = 4'b1111;
                store_data = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        stall_req = 1'b0;
        done      = 1'b0;
        rdata_out = '0;
        bus_err   = 1'b0;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_sel   = '0;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = ACCESS;
                    op_d      = op;
                    addr_d    = addr;
                    wdata_d   = wdata;
                    cnt_d     = '0;
                    stall_req = 1'b1;
                end
            end
            ACCESS: begin
                stall_req = 1'b1;
                mem_ce    = 1'b1;
                mem_we    = op_q[3];
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_sel   = op_q[3] ? store_sel : 4'b1111;
                mem_wdata = op_q[3] ? store_data : 32'b0;
                cnt_d     = cnt_q + 1'b1;
                // ack takes priority over a timeout landing in the same cycle
                if (mem_ack) begin
                    state_d = RESP;
                    rdata_d = op_q[3] ? 32'b0 : load_data;
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                done      = 1'b1;
                rdata_out = rdata_q;
                bus_err   = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table plus hand-written corner sequences,
// with a response scoreboard checked whenever done pulses.
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall_req;
    logic        done;
    logic [31:0] rdata_out;
    logic        misalign;
    logic        bus_err;
    logic        mem_ce;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .stall_req (stall_req),
        .done      (done),
        .rdata_out (rdata_out),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_sel   (mem_sel),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    // Memory model: ack on the (ack_wait+1)-th ACCESS cycle; ack_wait < 0 never acks.
    logic [31:0] mem_word;
    int          ack_wait;
    int          acc_cnt = 0;
    logic        stray_ack;

    always @(posedge clk) acc_cnt <= mem_ce ? acc_cnt + 1 : 0;

    assign mem_ack   = stray_ack | (mem_ce && ack_wait >= 0 && acc_cnt == ack_wait);
    assign mem_rdata = mem_ack ? mem_word : 32'hDEAD_BEEF;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL spurious_done: got done=1 expected no response");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check32("rdata_out", rdata_out, e.rdata);
                check32("bus_err", {31'b0, bus_err}, {31'b0, e.err});
            end
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] m;
        int          ack_wait;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_sel;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    task automatic run_vec(input vec_t v);
        int   lat;
        int   stalls;
        int   exp_lat;
        logic seen_bus;
        logic done_seen;
        lat       = 0;
        stalls    = 0;
        seen_bus  = 1'b0;
        done_seen = 1'b0;
        exp_lat   = (v.ack_wait < 0 || v.ack_wait >= TIMEOUT) ? TIMEOUT + 1 : v.ack_wait + 2;
        mem_word  = v.m;
        ack_wait  = v.ack_wait;
        op        = v.op;
        addr      = v.addr;
        wdata     = v.wdata;
        req_valid = 1'b1;
        sb.push_back('{v.exp_rdata, v.exp_err});
        while (!done_seen && lat < 40) begin
            @(negedge clk);
            if (lat == 0) check32("misalign_aligned", {31'b0, misalign}, 32'd0);
            if (stall_req) stalls++;
            if (mem_ce && !seen_bus) begin
                seen_bus = 1'b1;
                check32("mem_sel", {28'b0, mem_sel}, {28'b0, v.exp_sel});
                check32("mem_we", {31'b0, mem_we}, {31'b0, v.op[3]});
                check32("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
                if (v.op[3]) check32("mem_wdata", mem_wdata, v.exp_wdata);
            end
            if (done) begin
                done_seen = 1'b1;
                check32("mem_ce_in_resp", {31'b0, mem_ce}, 32'd0);
            end else begin
                lat++;
            end
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
        if (!done_seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_wait: got no done within 40 cycles expected done");
            sb.delete();
        end else begin
            check32("latency", 32'(lat), 32'(exp_lat));
            check32("stall_cycles", 32'(stalls), 32'(exp_lat));
            check32("bus_seen", {31'b0, seen_bus}, 32'd1);
        end
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        op        = 4'd0;
        addr      = '0;
        wdata     = '0;
        stray_ack = 1'b0;
        ack_wait  = 0;
        mem_word  = '0;

        //          op     addr          wdata         m             ack  rdata         err   sel      wdata
        vecs.push_back('{4'd8,  32'h0000_0003, 32'h0000_00FF, 32'h1234_5678, 0,  32'h0000_0000, 1'b0, 4'b0001, 32'hFFFF_FFFF});
        vecs.push_back('{4'd0,  32'h0000_0003, 32'h0,         32'h0000_00FF, 0,  32'hFFFF_FFFF, 1'b0, 4'b1111, 32'h0});
        vecs.push_back('{4'd1,  32'h0000_0003, 32'h0,         32'h0000_00FF, 0,  32'h0000_00FF, 1'b0, 4'b1111, 32'h0});
        vecs.push_back('{4'd2,  32'h0000_0002, 32'h0,         32'h4455_AABB, 0,  32'hFFFF_AABB, 1'b0, 4'b1111, 32'h0});
        vecs.push_back('{4'd3,  32'h0000_0002, 32'h0,         32'h4455_AABB, 0,  32'h0000_AABB, 1'b0, 4'b1111, 32'h0});
        vecs.push_back('{4'd5,  32'h0000_0001, 32'h1122_3344, 32'hAABB_CCDD, 0,  32'hBBCC_DD44, 1'b0, 4'b1111, 32'h0});
        vecs.push_back('{4'd6,  32'h0000_0002, 32'h1122_3344, 32'hAABB_CCDD, 0,  32'h11AA_BBCC, 1'b0, 4'b1111, 32'h0});
        vecs.push_back('{4'd12, 32'h0000_0001, 32'h4455_6677, 32'h9999_9999, 0,  32'h0,         1'b0, 4'b1100, 32'h6677_0000});
        vecs.push_back('{4'd11, 32'h0000_0002, 32'h4455_6677, 32'h9999_9999, 0,  32'h0,         1'b0, 4'b0011, 32'h0000_4455});
        vecs.push_back('{4'd4,  32'h0000_0100, 32'h0,         32'h1234_5678, 2,  32'h1234_5678, 1'b0, 4'b1111, 32'h0});
        vecs.push_back('{4'd9,  32'h0000_0006, 32'h0000_BEEF, 32'h7777_7777, 1,  32'h0,         1'b0, 4'b0011, 32'hBEEF_BEEF});
        vecs.push_back('{4'd0,  32'h0000_0011, 32'h0,         32'h0080_7F00, 0,  32'hFFFF_FF80, 1'b0, 4'b1111, 32'h0});
        vecs.push_back('{4'd2,  32'h0000_0020, 32'h0,         32'h7FFF_8000, 0,  32'h0000_7FFF, 1'b0, 4'b1111, 32'h0});
        vecs.push_back('{4'd5,  32'h0000_0030, 32'h5555_5555, 32'hCAFE_BABE, 0,  32'hCAFE_BABE, 1'b0, 4'b1111, 32'h0});
        vecs.push_back('{4'd6,  32'h0000_0033, 32'h5555_5555, 32'hCAFE_BABE, 0,  32'hCAFE_BABE, 1'b0, 4'b1111, 32'h0});
        vecs.push_back('{4'd10, 32'h0000_0008, 32'hA5A5_0F0F, 32'h1111_1111, 0,  32'h0,         1'b0, 4'b1111, 32'hA5A5_0F0F});
        vecs.push_back('{4'd8,  32'h0000_0040, 32'h1234_56AB, 32'h1111_1111, 0,  32'h0,         1'b0, 4'b1000, 32'hABAB_ABAB});
        vecs.push_back('{4'd4,  32'h0000_0200, 32'h0,         32'hFEED_FACE, -1, 32'h0,         1'b1, 4'b1111, 32'h0});
        vecs.push_back('{4'd4,  32'h0000_0204, 32'h0,         32'h1357_9BDF, 14, 32'h1357_9BDF, 1'b0, 4'b1111, 32'h0});

        // Everything must be quiet under reset, even with a request presented.
        #3;
        op        = 4'd4;
        req_valid = 1'b1;
        #1;
        check32("rst_stall", {31'b0, stall_req}, 32'd0);
        check32("rst_done", {31'b0, done}, 32'd0);
        check32("rst_mem_ce", {31'b0, mem_ce}, 32'd0);
        check32("rst_rdata", rdata_out, 32'd0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Misaligned halfword and word: flagged, no stall, no bus access.
        op        = 4'd2;
        addr      = 32'h0000_0001;
        req_valid = 1'b1;
        @(negedge clk);
        check32("misalign_lh", {31'b0, misalign}, 32'd1);
        check32("misalign_lh_stall", {31'b0, stall_req}, 32'd0);
        @(posedge clk);
        #1;
        op   = 4'd10;
        addr = 32'h0000_0042;
        @(negedge clk);
        check32("misalign_sw", {31'b0, misalign}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check32("misalign_no_ce", {31'b0, mem_ce}, 32'd0);
        check32("misalign_no_stall", {31'b0, stall_req}, 32'd0);

        // No-op codes and stray ack in IDLE are ignored.
        @(posedge clk);
        #1;
        op        = 4'd7;
        addr      = 32'h0;
        req_valid = 1'b1;
        stray_ack = 1'b1;
        @(negedge clk);
        check32("noop7_stall", {31'b0, stall_req}, 32'd0);
        @(posedge clk);
        #1;
        op = 4'd13;
        @(negedge clk);
        check32("noop13_stall", {31'b0, stall_req}, 32'd0);
        check32("noop_misalign", {31'b0, misalign}, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check32("noop_no_ce", {31'b0, mem_ce}, 32'd0);
        @(posedge clk);
        #1;
        stray_ack = 1'b0;

        // Reset during ACCESS: outputs drop at once, no done afterwards.
        ack_wait  = -1;
        op        = 4'd4;
        addr      = 32'h0000_0080;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check32("pre_rst_ce", {31'b0, mem_ce}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check32("midrst_ce", {31'b0, mem_ce}, 32'd0);
        check32("midrst_stall", {31'b0, stall_req}, 32'd0);
        check32("midrst_done", {31'b0, done}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check32("post_rst_idle", {31'b0, stall_req | mem_ce | done}, 32'd0);
        @(posedge clk);
        #1;
        run_vec('{4'd4, 32'h0000_0084, 32'h0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1'b0, 4'b1111, 32'h0});

        repeat (3) @(posedge clk);
        check32("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
